// File: rtl/sync_sched_pkg.sv
// Shared types and limits for the synchronizer-channel scheduler.
// Imported by rr_arbiter and sync_bus_scheduler.
package sync_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ASSERT  = 2'b01,
        RELEASE = 2'b10
    } sched_state_e;

    localparam int unsigned MAX_NUM_REQ = 16;
    localparam int unsigned MIN_HOLD    = 1;
    localparam int unsigned MIN_GAP     = 1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_bus_scheduler_rr_arbiter.sv
// Combinational requester picker: round-robin from ptr, or lowest index
// when SYNC_SCHED_FIXED_PRIO_EN is defined (ptr then ignored).
module rr_arbiter
    import sync_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   g
);

`ifdef SYNC_SCHED_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        logic found;
        grant = '0;
        g     = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && req[IDX_W'(k)]) begin
                found              = 1'b1;
                grant[IDX_W'(k)]   = 1'b1;
                g                  = IDX_W'(k);
            end
        end
    end
`else
    always_comb begin
        logic        found;
        int unsigned c;
        grant = '0;
        g     = '0;
        found = 1'b0;
        c     = 0;
        // Walk upward from ptr, wrapping, and stop at the first live request.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            c = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[c[IDX_W-1:0]]) begin
                found                = 1'b1;
                grant[c[IDX_W-1:0]]  = 1'b1;
                g                    = c[IDX_W-1:0];
            end
        end
    end
`endif

endmodule

// File: rtl/sync_bus_scheduler.sv
// Shares one bus synchronizer between NUM_REQ requesters: grant, hold enable
// HOLD_CYCLES, then gap GAP_CYCLES. Optional macro: SYNC_SCHED_FIXED_PRIO_EN.
module sync_bus_scheduler
    import sync_sched_pkg::*;
#(
    parameter int unsigned BUS_WIDTH   = 8,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           busy,
    output logic [BUS_WIDTH-1:0]           unsync_bus,
    output logic                           bus_enable
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, GAP_CYCLES) + 1);

    if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
        $error("sync_bus_scheduler: NUM_REQ must be within 2..16");
    end
    if (HOLD_CYCLES < MIN_HOLD) begin : g_bad_hold
        $error("sync_bus_scheduler: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < MIN_GAP) begin : g_bad_gap
        $error("sync_bus_scheduler: GAP_CYCLES must be >= 1");
    end

    sched_state_e         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] bus_q, bus_d;
    logic                 en_q, en_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;

    logic [IDX_W-1:0]     arb_ptr;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_g;

`ifdef SYNC_SCHED_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    assign arb_ptr = ptr_q;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (arb_ptr),
        .grant (arb_grant),
        .g     (arb_g)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bus_q   <= '0;
            en_q    <= 1'b0;
            ack_q   <= '0;
`ifndef SYNC_SCHED_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
`ifndef SYNC_SCHED_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        en_d    = en_q;
        ack_d   = '0;
`ifndef SYNC_SCHED_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    bus_d   = req_data[arb_g*BUS_WIDTH +: BUS_WIDTH];
                    en_d    = 1'b1;
                    ack_d   = arb_grant;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    state_d = ASSERT;
`ifndef SYNC_SCHED_FIXED_PRIO_EN
                    ptr_d   = (32'(arb_g) == NUM_REQ - 1) ? '0 : arb_g + 1'b1;
`endif
                end
            end
            ASSERT: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b0;
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RELEASE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    assign unsync_bus = bus_q;
    assign bus_enable = en_q;
    assign ack        = ack_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sync_bus_scheduler.sv
// Self-checking bench for sync_bus_scheduler: timer-based transfer model,
// directed scenarios and randomized request traffic.
module tb_sync_bus_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int H    = 4;
    localparam int G    = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic              busy;
    logic [W-1:0]      unsync_bus;
    logic              bus_enable;

    logic [NREQ-1:0]   req_f;
    logic [NREQ*W-1:0] req_data_f;
    logic [NREQ-1:0]   ack_f;
    logic              busy_f;
    logic [W-1:0]      bus_f;
    logic              en_f;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sync_bus_scheduler #(
        .BUS_WIDTH   (W),
        .NUM_REQ     (NREQ),
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .busy       (busy),
        .unsync_bus (unsync_bus),
        .bus_enable (bus_enable)
    );

    sync_bus_scheduler #(
        .BUS_WIDTH   (W),
        .NUM_REQ     (NREQ),
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (1)
    ) dut_fast (
        .CLK        (clk),
        .RST        (rst_n),
        .req        (req_f),
        .req_data   (req_data_f),
        .ack        (ack_f),
        .busy       (busy_f),
        .unsync_bus (bus_f),
        .bus_enable (en_f)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: a transfer is a timer of H+G cycles after the grant edge;
    // enable is high for its first H cycles, ack only on the first.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
`ifdef SYNC_SCHED_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`else
        for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
        return 0;
    endfunction

    bit         m_active;
    int         m_elapsed;
    int         m_ptr;
    int         m_g;
    logic [W-1:0] m_bus;
    int         m_pick;
    bit         chk_en = 1'b1;

    always_comb m_pick = pick(req, m_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active  <= 1'b0;
            m_elapsed <= 0;
            m_ptr     <= 0;
            m_g       <= 0;
            m_bus     <= '0;
        end else if (m_active) begin
            m_elapsed <= m_elapsed + 1;
            if (m_elapsed + 1 == H + G) m_active <= 1'b0;
        end else if (req != '0) begin
            m_active  <= 1'b1;
            m_elapsed <= 0;
            m_g       <= m_pick;
            m_bus     <= req_data[m_pick*W +: W];
            m_ptr     <= (m_pick + 1) % NREQ;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n && chk_en) begin
            chk("model_bus", 32'(unsync_bus), 32'(m_bus));
            chk("model_en", 32'(bus_enable), 32'(m_active && m_elapsed < H));
            chk("model_ack", 32'(ack), (m_active && m_elapsed == 0) ? (32'd1 << m_g) : 32'd0);
            chk("model_busy", 32'(busy), 32'(m_active));
        end
    end

    task automatic wait_ack(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ack != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no ack within 40 cycles", tag);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int t0;
        int idx;
        logic [31:0] word;

        req        = '0;
        req_data   = '0;
        req_f      = '0;
        req_data_f = 32'hDDCC_BBAA;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bus", 32'(unsync_bus), 32'h0);
        chk("rst_en", 32'(bus_enable), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        // Single request, enable/busy shape.
        @(negedge clk);
        req      = 4'b0010;
        req_data = 32'h0000_A500;
        wait_ack("t1_ack", ok);
        chk("t1_bus", 32'(unsync_bus), 32'hA5);
        chk("t1_ack", 32'(ack), 32'b0010);
        for (int k = 0; k < 9; k++) begin
            chk("t1_en", 32'(bus_enable), 32'(k < H));
            chk("t1_busy", 32'(busy), 32'(k < H + G));
            chk("t1_ackpulse", 32'(ack), (k == 0) ? 32'b0010 : 32'h0);
            @(negedge clk);
            req = '0;
            @(posedge clk);
            #1;
        end

        // All requesting: grant order and spacing.
        do_reset();
        req      = 4'b1111;
        req_data = 32'h4030_2010;
        t0 = 0;
        for (int n = 0; n < 5; n++) begin
            wait_ack("t2_ack", ok);
`ifdef SYNC_SCHED_FIXED_PRIO_EN
            idx = 0;
`else
            idx = n % NREQ;
`endif
            word = req_data >> (idx * W);
            chk("t2_grant", 32'(ack), 32'd1 << idx);
            chk("t2_bus", 32'(unsync_bus), {24'h0, word[7:0]});
            if (n > 0) chk("t2_spacing", 32'(cyc - t0), 32'(H + G + 1));
            t0 = cyc;
        end
        @(negedge clk);
        req = '0;
        repeat (12) @(negedge clk);

        // Data change and new request during ASSERT are ignored.
        do_reset();
        req      = 4'b0001;
        req_data = 32'h0000_0011;
        wait_ack("t3_ack0", ok);
        t0 = cyc;
        @(negedge clk);
        req      = 4'b0010;
        req_data = 32'h0000_22FF;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("t3_frozen", 32'(unsync_bus), 32'h11);
        end
        wait_ack("t3_ack1", ok);
        chk("t3_grant1", 32'(ack), 32'b0010);
        chk("t3_spacing", 32'(cyc - t0), 32'(H + G + 1));
        chk("t3_bus1", 32'(unsync_bus), 32'h22);
        @(negedge clk);
        req = '0;
        repeat (12) @(negedge clk);

        // Asynchronous reset in the second ASSERT cycle.
        do_reset();
        req      = 4'b0010;
        req_data = 32'h0000_3300;
        wait_ack("t4_ack0", ok);
        @(negedge clk);
        req = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_bus", 32'(unsync_bus), 32'h0);
        chk("t4_rst_en", 32'(bus_enable), 32'h0);
        chk("t4_rst_busy", 32'(busy), 32'h0);
        chk("t4_rst_ack", 32'(ack), 32'h0);
        @(negedge clk);
        req      = 4'b0101;
        req_data = 32'h0055_0066;
        rst_n    = 1'b1;
        wait_ack("t4_ack1", ok);
        chk("t4_grant", 32'(ack), 32'b0001);
        chk("t4_bus", 32'(unsync_bus), 32'h66);
        @(negedge clk);
        req = '0;
        repeat (12) @(negedge clk);

        // HOLD=1/GAP=1 instance, single held request.
        req_f = 4'b0001;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (ack_f != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL t5_ack: no ack within 10 cycles");
        end
        for (int k = 0; k < 9; k++) begin
            chk("t5_en", 32'(en_f), 32'(k % 3 == 0));
            chk("t5_ack", 32'(ack_f), (k % 3 == 0) ? 32'b0001 : 32'h0);
            chk("t5_busy", 32'(busy_f), 32'(k % 3 != 2));
            chk("t5_bus", 32'(bus_f), 32'hAA);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        req_f = '0;

        // Randomized traffic against the model.
        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i]            = 1'b1;
                    req_data[i*W +: W] = 8'($urandom);
                end else if (req[i] && $urandom_range(0, 31) == 0) begin
                    req[i] = 1'b0;
                end
                if ($urandom_range(0, 15) == 0) req_data[i*W +: W] = 8'($urandom);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = '0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
